// File: rtl/mem_io_unit.sv
`default_nettype none
// =====================================================================
// mem_io_unit : LC-3 memory-access stage holding MAR/MDR, running a
//               req/ready memory handshake and local keyboard/display regs
// Rev 1.0
// =====================================================================
module mem_io_unit (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] Bus_In,
   input  logic        LD_MAR,
   input  logic        LD_MDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic [15:0] MAR,
   output logic [15:0] MDR,
   output logic        R,
   output logic        Mem_Req,
   output logic        Mem_WE,
   output logic [15:0] Mem_Addr,
   output logic [15:0] Mem_WData,
   input  logic [15:0] Mem_RData,
   input  logic        Mem_Ready,
   input  logic        Kb_Strobe,
   input  logic [7:0]  Kb_Data,
   input  logic        Disp_Ready,
   output logic        Disp_Valid,
   output logic [7:0]  Disp_Data
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DONE     = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] mdr_q, mdr_d;
   logic [7:0]  kbdr_q, kbdr_d;
   logic [7:0]  disp_data_q, disp_data_d;
   logic        kb_ready_q, kb_ready_d;
   logic        rw_q, rw_d;
   logic        r_q, r_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic        disp_valid_q, disp_valid_d;
   logic        is_dev;

   // Device registers sit at the four even addresses xFE00..xFE06
   assign is_dev = (mar_q[15:3] == 13'h1FC0) && !mar_q[0];

   always_comb begin
      state_d      = state_q;
      mar_d        = mar_q;
      mdr_d        = mdr_q;
      kbdr_d       = kbdr_q;
      kb_ready_d   = kb_ready_q;
      disp_data_d  = disp_data_q;
      rw_d         = rw_q;
      r_d          = 1'b0;
      mem_req_d    = 1'b0;
      mem_we_d     = 1'b0;
      disp_valid_d = 1'b0;

      if (LD_MDR && !MIO_EN) begin
         mdr_d = Bus_In;
      end
      if (Kb_Strobe) begin
         kbdr_d = Kb_Data;
      end

      case (state_q)
         IDLE: begin
            if (LD_MAR) begin
               mar_d = Bus_In;
            end
            if (MIO_EN) begin
               rw_d = R_W;
               if (is_dev) begin
                  state_d = DONE;
                  r_d     = 1'b1;
                  if (!R_W) begin
                     case (mar_q[2:1])
                        2'd0: mdr_d = {kb_ready_q, 15'b0};
                        2'd1: begin
                           mdr_d      = {8'h00, kbdr_q};
                           kb_ready_d = 1'b0;
                        end
                        2'd2: mdr_d = {Disp_Ready, 15'b0};
                        2'd3: mdr_d = 16'h0000;
                     endcase
                  end else if (mar_q[2:1] == 2'd3) begin
                     disp_data_d  = mdr_q[7:0];
                     disp_valid_d = 1'b1;
                  end
               end else begin
                  state_d   = MEM_WAIT;
                  mem_req_d = 1'b1;
                  mem_we_d  = R_W;
               end
            end
         end
         MEM_WAIT: begin
            if (Mem_Ready) begin
               state_d = DONE;
               r_d     = 1'b1;
               if (!rw_q) begin
                  mdr_d = Mem_RData;
               end
            end else begin
               mem_req_d = 1'b1;
               mem_we_d  = rw_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A new key arriving with a KBDR read leaves the ready flag set
      if (Kb_Strobe) begin
         kb_ready_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         mar_q        <= 16'h0000;
         mdr_q        <= 16'h0000;
         kbdr_q       <= 8'h00;
         kb_ready_q   <= 1'b0;
         disp_data_q  <= 8'h00;
         rw_q         <= 1'b0;
         r_q          <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         disp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mar_q        <= mar_d;
         mdr_q        <= mdr_d;
         kbdr_q       <= kbdr_d;
         kb_ready_q   <= kb_ready_d;
         disp_data_q  <= disp_data_d;
         rw_q         <= rw_d;
         r_q          <= r_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         disp_valid_q <= disp_valid_d;
      end
   end

   assign MAR        = mar_q;
   assign MDR        = mdr_q;
   assign R          = r_q;
   assign Mem_Req    = mem_req_q;
   assign Mem_WE     = mem_we_q;
   assign Mem_Addr   = mar_q;
   assign Mem_WData  = mdr_q;
   assign Disp_Valid = disp_valid_q;
   assign Disp_Data  = disp_data_q;

endmodule
`default_nettype wire

// File: doc/mem_io_unit.md
# mem_io_unit

Memory-access stage directly downstream of the MAR address mux. It latches the effective address from the system bus into MAR, holds MDR, and runs one memory or device access per control request. Memory accesses use a variable-latency req/ready handshake. Device-register addresses (keyboard, display) are served locally. It returns the LC-3 ready flag R to the control FSM.

## Interface
- No parameters; all datapaths fixed at 16 bits.
- Clk  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Bus_In  in  16  system bus; carries the MAR-mux output during MAR loads and register/ALU values during MDR loads.
- LD_MAR  in  1  load MAR from Bus_In.
- LD_MDR  in  1  load MDR from Bus_In; honoured only when MIO_EN=0.
- MIO_EN  in  1  request an access at address MAR.
- R_W  in  1  access direction: 1 = write, 0 = read; sampled with MIO_EN.
- MAR  out  16  memory address register.
- MDR  out  16  memory data register.
- R  out  1  access complete; one-cycle pulse.
- Mem_Req  out  1  memory request; high throughout MEM_WAIT.
- Mem_WE  out  1  write enable; equals the latched R_W while Mem_Req=1, otherwise 0.
- Mem_Addr  out  16  equals MAR.
- Mem_WData  out  16  equals MDR.
- Mem_RData  in  16  read data; valid when Mem_Ready=1.
- Mem_Ready  in  1  memory completion.
- Kb_Strobe  in  1  one-cycle pulse marking a new key.
- Kb_Data  in  8  key code; valid with Kb_Strobe.
- Disp_Ready  in  1  display can accept a character.
- Disp_Valid  out  1  one-cycle pulse; Disp_Data is valid during it.
- Disp_Data  out  8  character to the display.

## Operation
- Reset values: MAR, MDR, Disp_Data = x0000; R, Mem_Req, Mem_WE, Disp_Valid = 0; Kb_Ready = 0; internal KBDR = x00; state IDLE.
- Reset is asynchronous and may arrive mid-access. Mem_Req drops immediately and any pending access is abandoned with no R.
- LD_MAR loads MAR only in IDLE; it is ignored in MEM_WAIT and DONE.
- LD_MDR with MIO_EN=0 loads MDR from Bus_In in any state.
- FSM states: IDLE, MEM_WAIT, DONE.
- IDLE with MIO_EN=1 latches R_W and decodes MAR:
  - Device address (xFE00, xFE02, xFE04, xFE06): the access completes at the same edge and the FSM goes to DONE.
  - Any other address (including other xFExx): FSM goes to MEM_WAIT.
- MEM_WAIT: Mem_Req=1. Mem_Ready=1 moves the FSM to DONE. On a read, MDR loads Mem_RData at that edge. Mem_Ready=0 holds the state indefinitely; there is no timeout.
- DONE: R=1 for exactly one cycle, then the FSM returns to IDLE unconditionally. MIO_EN high on the following IDLE cycle starts a new access.
- Mem_Ready outside MEM_WAIT is ignored.
- Device register reads (result loaded into MDR):
  - KBSR (xFE00) = {Kb_Ready, 15'b0}.
  - KBDR (xFE02) = {8'h00, KBDR}; a KBDR read clears Kb_Ready.
  - DSR (xFE04) = {Disp_Ready, 15'b0}.
  - DDR (xFE06) reads x0000.
- Device register writes:
  - DDR write: Disp_Data <= MDR[7:0]; Disp_Valid pulses in the next cycle, regardless of Disp_Ready (software polls DSR).
  - Writes to KBSR, KBDR and DSR are ignored but still complete with R.
- Kb_Strobe: KBDR <= Kb_Data and Kb_Ready <= 1. A second strobe before software reads overwrites KBDR.
- Kb_Strobe in the same edge as a KBDR read:
  - MDR receives the old KBDR value.
  - KBDR takes the new value.
  - Kb_Ready ends at 1 (set wins over clear).

## Timing
- Memory access: MIO_EN sampled at edge N; Mem_Req high from N+1. If Mem_Ready is sampled high at edge M (M >= N+1), R is high in cycle M..M+1. Minimum three cycles from MIO_EN to the end of R.
- Device access: MIO_EN sampled at edge N; R is high in cycle N..N+1; MDR or Disp_Data is updated at edge N.
- Mem_Addr, Mem_WData and Mem_WE are stable throughout MEM_WAIT, because MAR is frozen and the control FSM does not pulse LD_MDR during writes.
- All outputs are registered or pure decodes of state and registers. There is no combinational path from Mem_Ready to R.

## Test plan
- Memory read, 2 wait cycles: LD_MAR with Bus_In=x3000; MIO_EN=1, R_W=0; Mem_Ready high on the 3rd MEM_WAIT cycle with Mem_RData=xBEEF -> Mem_Addr=x3000 and Mem_WE=0 throughout; MDR=xBEEF; exactly one R pulse.
- Memory write, zero wait: MAR=x4000, MDR=x1234; MIO_EN=1, R_W=1; Mem_Ready high in the first MEM_WAIT cycle -> Mem_WE=1 and Mem_WData=x1234 for one cycle; R in the following cycle.
- Keyboard: Kb_Strobe with Kb_Data=x41 -> KBSR read gives x8000; KBDR read gives x0041; a second KBSR read gives x0000. Repeat with the strobe coincident with the KBDR read -> Kb_Ready stays set.
- Display: DSR read with Disp_Ready=1 -> x8000. DDR write with MDR=x0058 -> Disp_Data=x58; single Disp_Valid pulse; Mem_Req never asserts.
- LD_MAR during MEM_WAIT with Bus_In=xFFFF -> MAR and Mem_Addr unchanged until R.
- Reset_n low mid-MEM_WAIT -> Mem_Req=0 immediately; no R pulse; MAR=MDR=x0000; the next access starts cleanly.
